// File: rtl/sm_run_ctrl.sv
// Run-control sequencer for the CPU clock path.
// Produces a registered one-cycle CPU advance enable (cpuEn) from a power-of-two
// prescaler. Supports free run, halt, N-step and a single PC breakpoint.
module sm_run_ctrl #(
  parameter int unsigned SHIFT  = 16,  // base prescaler exponent, SHIFT+15 <= 31
  parameter int unsigned STEP_W = 16   // step counter width
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        devide,
  input  logic              cmdRun,
  input  logic              cmdHalt,
  input  logic              cmdStep,
  input  logic [STEP_W-1:0] stepCount,
  input  logic              bpEnable,
  input  logic [31:0]       bpAddr,
  input  logic [31:0]       pc,
  output logic              cpuEn,
  output logic [1:0]        state,
  output logic              bpHit,
  output logic [31:0]       cycles
);

  typedef enum logic [1:0] {
    StHalt = 2'd0,
    StRun  = 2'd1,
    StStep = 2'd2
  } state_e;

  state_e            st_q;
  logic [31:0]       cntr_q;
  logic [STEP_W-1:0] remain_q;
  logic              first_q;

  logic [5:0]        expo;
  logic [31:0]       term;
  logic              active;
  logic              tick;
  logic              over;
  logic              bp_match;
  logic              step_ok;

  assign state = st_q;

  // Prescaler terminal count, tick and breakpoint decode.
  always_comb begin
    expo     = 6'(SHIFT) + {2'b00, devide};
    term     = (32'd1 << expo) - 32'd1;
    active   = (st_q != StHalt);
    tick     = active && (cntr_q == term);
    // Counter past a freshly lowered terminal: wrap quietly, no tick.
    over     = active && (cntr_q > term);
    // The first tick after entry skips the compare so resuming from a breakpoint advances.
    bp_match = bpEnable && (pc == bpAddr) && !first_q;
    step_ok  = cmdStep && (stepCount != '0);
  end

  // Sequencer state, prescaler, step counter and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q     <= StHalt;
      cntr_q   <= 32'd0;
      remain_q <= '0;
      first_q  <= 1'b0;
      cpuEn    <= 1'b0;
      bpHit    <= 1'b0;
      cycles   <= 32'd0;
    end else begin
      cpuEn <= 1'b0;
      unique case (st_q)
        StHalt: begin
          if (cmdHalt) begin
            // Highest priority command; nothing to do while already halted.
          end else if (step_ok) begin
            st_q     <= StStep;
            remain_q <= stepCount;
            first_q  <= 1'b1;
            cntr_q   <= 32'd0;
            bpHit    <= 1'b0;
          end else if (cmdRun) begin
            st_q    <= StRun;
            first_q <= 1'b1;
            cntr_q  <= 32'd0;
            bpHit   <= 1'b0;
          end
        end

        StRun: begin
          if (cmdHalt) begin
            // A tick coinciding with halt is dropped.
            st_q <= StHalt;
          end else if (over) begin
            cntr_q <= 32'd0;
          end else if (tick) begin
            cntr_q  <= 32'd0;
            first_q <= 1'b0;
            if (bp_match) begin
              st_q  <= StHalt;
              bpHit <= 1'b1;
            end else begin
              cpuEn  <= 1'b1;
              cycles <= cycles + 32'd1;
            end
          end else begin
            cntr_q <= cntr_q + 32'd1;
          end
        end

        StStep: begin
          if (cmdHalt) begin
            st_q     <= StHalt;
            remain_q <= '0;
          end else if (over) begin
            cntr_q <= 32'd0;
          end else if (tick) begin
            cntr_q  <= 32'd0;
            first_q <= 1'b0;
            if (bp_match) begin
              st_q     <= StHalt;
              bpHit    <= 1'b1;
              remain_q <= '0;
            end else begin
              cpuEn    <= 1'b1;
              cycles   <= cycles + 32'd1;
              remain_q <= remain_q - STEP_W'(1);
              // Last step halts on the same edge that registers its enable.
              if (remain_q == STEP_W'(1)) begin
                st_q <= StHalt;
              end
            end
          end else begin
            cntr_q <= cntr_q + 32'd1;
          end
        end

        default: begin
          st_q <= StHalt;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sm_run_ctrl.sv
// Scoreboard bench for sm_run_ctrl: stimulus pushes expected cpuEn pulses
// (edge number and cycles value); a negedge monitor pops and compares.
module tb_sm_run_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  devide;
  logic        cmdRun;
  logic        cmdHalt;
  logic        cmdStep;
  logic [15:0] stepCount;
  logic        bpEnable;
  logic [31:0] bpAddr;
  logic [31:0] pc;
  logic        cpuEn;
  logic [1:0]  state;
  logic        bpHit;
  logic [31:0] cycles;

  typedef struct {
    int edge_n;
    int cyc;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   ecnt       = 0;
  int   tests      = 0;
  int   fails      = 0;
  int   exp_cycles = 0;
  int   pulse_seen = 0;
  int   pc_base    = 0;
  int   e;

  // Simple CPU model: fetch address advances by 4 per enable.
  assign pc = 32'((pulse_seen - pc_base) * 4);

  sm_run_ctrl #(
    .SHIFT  (0),
    .STEP_W (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .devide    (devide),
    .cmdRun    (cmdRun),
    .cmdHalt   (cmdHalt),
    .cmdStep   (cmdStep),
    .stepCount (stepCount),
    .bpEnable  (bpEnable),
    .bpAddr    (bpAddr),
    .pc        (pc),
    .cpuEn     (cpuEn),
    .state     (state),
    .bpHit     (bpHit),
    .cycles    (cycles)
  );

  always #5 clk = ~clk;

  always @(posedge clk) ecnt++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h (edge %0d)", name, act, req, ecnt);
    end
  endtask

  task automatic push(input int edge_n);
    exp_t x;
    exp_cycles++;
    x.edge_n = edge_n;
    x.cyc    = exp_cycles;
    q.push_back(x);
  endtask

  // Drive a command at a negedge; it is sampled on the next posedge, returned as e_out.
  task automatic issue(input logic r, input logic h, input logic s, input logic [15:0] n,
                       output int e_out);
    cmdRun    = r;
    cmdHalt   = h;
    cmdStep   = s;
    stepCount = n;
    e_out     = ecnt + 1;
    @(negedge clk);
    cmdRun  = 1'b0;
    cmdHalt = 1'b0;
    cmdStep = 1'b0;
  endtask

  task automatic wait_neg(input int n);
    while (ecnt < n) @(negedge clk);
  endtask

  // Monitor: every cpuEn pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && cpuEn) begin
      pulse_seen++;
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_pulse: cpuEn=1 at edge %0d, required no pulse", ecnt);
      end else begin
        mon_e = q.pop_front();
        check("pulse_edge", ecnt, mon_e.edge_n);
        check("pulse_cycles", cycles, mon_e.cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1);
  end

  initial begin
    rst       = 1'b0;
    devide    = 4'd2;
    cmdRun    = 1'b0;
    cmdHalt   = 1'b0;
    cmdStep   = 1'b0;
    stepCount = 16'd0;
    bpEnable  = 1'b0;
    bpAddr    = 32'h10;
    #1 rst = 1'b1;
    #1;
    check("rst0_state", 32'(state), 32'd0);
    check("rst0_cpuen", 32'(cpuEn), 32'd0);
    check("rst0_cycles", cycles, 32'd0);
    check("rst0_bphit", 32'(bpHit), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Async reset in the middle of a run, while cpuEn is high.
    issue(1'b1, 1'b0, 1'b0, 16'd0, e);
    push(e + 4);
    push(e + 8);
    wait_neg(e + 8);
    #2 rst = 1'b1;
    #1;
    check("rst_state", 32'(state), 32'd0);
    check("rst_cpuen", 32'(cpuEn), 32'd0);
    check("rst_cycles", cycles, 32'd0);
    check("rst_bphit", 32'(bpHit), 32'd0);
    check("rst_q_empty", 32'(q.size()), 32'd0);
    exp_cycles = 0;
    @(negedge clk);
    rst = 1'b0;
    repeat (100) @(negedge clk);

    // Free run at period 4; halt lands on a tick cycle and must drop it.
    issue(1'b1, 1'b0, 1'b0, 16'd0, e);
    check("run_state", 32'(state), 32'd1);
    push(e + 4);
    push(e + 8);
    push(e + 12);
    wait_neg(e + 15);
    issue(1'b0, 1'b1, 1'b0, 16'd0, e);
    repeat (20) @(negedge clk);
    check("run_halt_state", 32'(state), 32'd0);
    check("run_q_empty", 32'(q.size()), 32'd0);

    // Three back-to-back steps, then a zero-count step is ignored.
    devide = 4'd0;
    issue(1'b0, 1'b0, 1'b1, 16'd3, e);
    check("step_state", 32'(state), 32'd2);
    push(e + 1);
    push(e + 2);
    push(e + 3);
    repeat (10) @(negedge clk);
    check("step_done_state", 32'(state), 32'd0);
    check("step_cycles", cycles, 32'(exp_cycles));
    check("step_q_empty", 32'(q.size()), 32'd0);
    issue(1'b0, 1'b0, 1'b1, 16'd0, e);
    check("step0_state", 32'(state), 32'd0);
    repeat (10) @(negedge clk);
    check("step0_cycles", cycles, 32'(exp_cycles));

    // Breakpoint at 0x10: four pulses then halt with bpHit.
    devide   = 4'd1;
    bpEnable = 1'b1;
    pc_base  = pulse_seen;
    issue(1'b1, 1'b0, 1'b0, 16'd0, e);
    push(e + 2);
    push(e + 4);
    push(e + 6);
    push(e + 8);
    repeat (20) @(negedge clk);
    check("bp_state", 32'(state), 32'd0);
    check("bp_hit", 32'(bpHit), 32'd1);
    check("bp_cycles", cycles, 32'(exp_cycles));
    check("bp_q_empty", 32'(q.size()), 32'd0);
    issue(1'b0, 1'b1, 1'b0, 16'd0, e);
    check("bp_sticky_halt", 32'(bpHit), 32'd1);
    // Single step from the breakpoint PC must advance.
    issue(1'b0, 1'b0, 1'b1, 16'd1, e);
    check("bp_clr_on_step", 32'(bpHit), 32'd0);
    push(e + 2);
    repeat (10) @(negedge clk);
    check("bp_step_state", 32'(state), 32'd0);
    check("bp_step_hit", 32'(bpHit), 32'd0);
    check("bp_step_q_empty", 32'(q.size()), 32'd0);

    // Halt beats run in the same cycle; halt aborts a long step.
    bpEnable = 1'b0;
    issue(1'b1, 1'b1, 1'b0, 16'd0, e);
    repeat (5) @(negedge clk);
    check("prio_state", 32'(state), 32'd0);
    issue(1'b0, 1'b0, 1'b1, 16'd10, e);
    push(e + 2);
    push(e + 4);
    wait_neg(e + 4);
    issue(1'b0, 1'b1, 1'b0, 16'd0, e);
    repeat (20) @(negedge clk);
    check("abort_state", 32'(state), 32'd0);
    check("abort_cycles", cycles, 32'(exp_cycles));
    check("abort_q_empty", 32'(q.size()), 32'd0);

    // Lower devide while the counter is beyond the new terminal.
    devide = 4'd3;
    issue(1'b1, 1'b0, 1'b0, 16'd0, e);
    check("dev_state", 32'(state), 32'd1);
    wait_neg(e + 6);
    devide = 4'd1;
    push(e + 9);
    push(e + 11);
    push(e + 13);
    wait_neg(e + 13);
    issue(1'b0, 1'b1, 1'b0, 16'd0, e);
    repeat (10) @(negedge clk);
    check("dev_halt_state", 32'(state), 32'd0);
    check("dev_cycles", cycles, 32'(exp_cycles));
    check("dev_q_empty", 32'(q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
